// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from an internal bit-period counter, valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
    parameter int BAUD_RATE    = 9600,
    parameter int CLOCK_FREQ   = 192000,
    parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif

    logic             rx_meta_q, rxs_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             byte_done;
`ifdef UART_RX_PARITY_EN
    logic             parity_q, parity_d;
    logic             parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rxs_q) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d    = '0;
                    parity_d = rxs_q;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here until the line returns high so a stuck-low line cannot fake a start bit.
                cnt_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output holding register: a completed byte loads only if the slot is free or being emptied now.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (byte_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
`ifdef UART_RX_PARITY_EN
        parity_err_d = byte_done && ((^shift_q) ^ parity_q);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, delivered bytes checked against an expected queue.
// Exercises the parity path too when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  localparam int CPB = 20;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = CPB * NBITS;
  // posedges from the start-bit falling edge until rx_valid is visible
  localparam int DONE_EDGES = CPB / 2 + (NBITS - 1) * CPB + 3;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip;
`endif

  int tests = 0;
  int fails = 0;
  int frame_err_cnt = 0;
  int overrun_cnt = 0;
  int fe0, ov0;
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: call at a negedge; leaves rx at the stop-bit level
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  // scoreboard: every accepted byte must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_data", rx_data, exp_q.pop_front());
    end
    if (frame_err) frame_err_cnt++;
    if (overrun) overrun_cnt++;
  end

  initial begin
    rx = 1'b1;
    rx_ready = 1'b1;
    reset = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 with exact delivery timing
    fe0 = frame_err_cnt;
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (DONE_EDGES - 1) @(posedge clk);
        @(negedge clk);
        check("a5_valid_early", rx_valid, 1'b0);
        @(negedge clk);
        check("a5_valid", rx_valid, 1'b1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_frame_err", frame_err, 1'b0);
        @(negedge clk);
        check("a5_valid_clear", rx_valid, 1'b0);
      end
    join
    check("a5_no_fe", frame_err_cnt - fe0, 0);

    // back-to-back 0x3C, 0x81 with consumer stalled
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    ov0 = overrun_cnt;
    exp_q.push_back(8'h3C);
    fork
      begin
        send_byte(8'h3C, 1'b1);
        send_byte(8'h81, 1'b1);
      end
      begin
        repeat (FRAME_CLKS + DONE_EDGES - 1) @(posedge clk);
        @(negedge clk);
        check("ovr_early", overrun, 1'b0);
        @(negedge clk);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_data_held", rx_data, 8'h3C);
        check("ovr_valid_held", rx_valid, 1'b1);
      end
    join
    repeat (10) @(negedge clk);
    check("ovr_count", overrun_cnt - ov0, 1);
    check("ovr_data_after", rx_data, 8'h3C);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_drained", rx_valid, 1'b0);

    // 5-clock glitch is rejected as a false start
    fe0 = frame_err_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy", busy, 1'b1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_idle", busy, 1'b0);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_no_fe", frame_err_cnt - fe0, 0);

    // 0x55 with a low stop bit, then the line held low
    fe0 = frame_err_cnt;
    fork
      send_byte(8'h55, 1'b0);
      begin
        repeat (DONE_EDGES - 1) @(posedge clk);
        @(negedge clk);
        check("fe_early", frame_err, 1'b0);
        @(negedge clk);
        check("fe_pulse", frame_err, 1'b1);
        check("fe_no_valid", rx_valid, 1'b0);
        @(negedge clk);
        check("fe_one_cycle", frame_err, 1'b0);
      end
    join
    repeat (40) @(negedge clk);
    check("fe_break_busy", busy, 1'b1);
    check("fe_count", frame_err_cnt - fe0, 1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("fe_break_exit", busy, 1'b0);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    repeat (10) @(negedge clk);
    check("after_fe_data", rx_data, 8'h12);
    check("after_fe_valid", rx_valid, 1'b0);

    // reset during bit 4 of 0xF3; the tail of that frame must not produce a byte
    fork
      send_byte(8'hF3, 1'b1);
      begin
        repeat (CPB * 5 + CPB / 2) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_fe", frame_err, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        reset = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("mid_tail_idle", busy, 1'b0);
    exp_q.push_back(8'hF0);
    send_byte(8'hF0, 1'b1);
    repeat (10) @(negedge clk);
    check("post_rst_data", rx_data, 8'hF0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd data parity: parity bit 0 is an error, parity bit 1 is clean
    par_flip = 1'b1;
    exp_q.push_back(8'h07);
    fork
      send_byte(8'h07, 1'b1);
      begin
        repeat (DONE_EDGES - 1) @(posedge clk);
        @(negedge clk);
        check("par_err_early", parity_err, 1'b0);
        @(negedge clk);
        check("par_err_pulse", parity_err, 1'b1);
        check("par_err_data", rx_data, 8'h07);
      end
    join
    par_flip = 1'b0;
    exp_q.push_back(8'h07);
    fork
      send_byte(8'h07, 1'b1);
      begin
        repeat (DONE_EDGES) @(posedge clk);
        @(negedge clk);
        check("par_ok_valid", rx_valid, 1'b1);
        check("par_ok_no_err", parity_err, 1'b0);
      end
    join
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
